// File: rtl/mux_pkg.sv
// mux_pkg: shared select encoding and helpers for the 1-of-4 data selector.
//   sel_t           : 2-bit select code
//   SEL_A..SEL_D    : select codes for sources a..d
//   sel_changed()   : true when two select codes differ
package mux_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

  // A select change is any difference between the new and the held code.
  function automatic logic sel_changed(input sel_t new_sel, input sel_t old_sel);
    return (new_sel != old_sel);
  endfunction

endpackage

// File: rtl/mux4_core.sv
// mux4_core: purely combinational 1-of-4 selector.
//   a, b, c, d : WIDTH-bit data sources
//   sel        : select code (SEL_A..SEL_D)
//   out        : selected data, zero latency
module mux4_core
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic [WIDTH-1:0] out
);

  // Source selection; an unknown select yields X in simulation so that a bad
  // select upstream is visible rather than silently picking a source.
  always_comb begin
    out = {WIDTH{1'b0}};
    case (sel)
      SEL_A:   out = a;
      SEL_B:   out = b;
      SEL_C:   out = c;
      SEL_D:   out = d;
      default: out = {WIDTH{1'bx}};
    endcase
  end

endmodule

// File: rtl/better_mux_4.sv
// better_mux_4: 1-of-4 data selector with combinational and registered outputs.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset (clears registered outputs only)
//   a..d    : WIDTH-bit data sources for sel 00..11
//   sel     : source select
//   out     : combinational selected data
//   out_q   : out delayed by exactly one clock
//   sel_chg : one-cycle pulse after a sampled select change
module better_mux_4
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_chg
);

  logic [WIDTH-1:0] out_q_d;
  sel_t             sel_q;
  sel_t             sel_d;
  logic             sel_chg_q;
  logic             sel_chg_d;

  mux4_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a  (a),
    .b  (b),
    .c  (c),
    .d  (d),
    .sel(sel),
    .out(out)
  );

  // Next-state values: capture the current selection and compare the live
  // select with the held one (held value is 00 after reset, so a first
  // non-zero select produces a pulse).
  always_comb begin
    out_q_d   = out;
    sel_d     = sel;
    sel_chg_d = sel_changed(sel, sel_q);
  end

  // Output and select registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= {WIDTH{1'b0}};
      sel_q     <= SEL_A;
      sel_chg_q <= 1'b0;
    end else begin
      out_q     <= out_q_d;
      sel_q     <= sel_d;
      sel_chg_q <= sel_chg_d;
    end
  end

  assign sel_chg = sel_chg_q;

endmodule

// File: tb/tb_better_mux_4.sv
module tb_better_mux_4;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a, b, c, d;
  logic [1:0]   sel;
  logic [W-1:0] out;
  logic [W-1:0] out_q;
  logic         sel_chg;

  int checks   = 0;
  int failures = 0;

  // Reference model state: what the registered outputs should hold.
  logic [W-1:0] m_out_q;
  logic [1:0]   m_sel_q;
  logic         m_chg;

  better_mux_4 #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .sel    (sel),
    .out    (out),
    .out_q  (out_q),
    .sel_chg(sel_chg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // The selected source is simply the input table indexed by the select value.
  function automatic logic [W-1:0] pick(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                         input logic [W-1:0] ic, input logic [W-1:0] id,
                                         input logic [1:0] s);
    logic [W-1:0] tbl [4];
    tbl[0] = ia; tbl[1] = ib; tbl[2] = ic; tbl[3] = id;
    return tbl[s];
  endfunction

  // Registered behaviour: last cycle's selection, last cycle's select, and
  // whether the select sampled now differs from the one sampled before.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out_q <= '0;
      m_sel_q <= 2'b00;
      m_chg   <= 1'b0;
    end else begin
      m_out_q <= pick(a, b, c, d, sel);
      m_chg   <= (sel != m_sel_q);
      m_sel_q <= sel;
    end
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_out_q"}, out_q, m_out_q);
    check({tag, "_sel_chg"}, {7'd0, sel_chg}, {7'd0, m_chg});
  endtask

  initial begin
    rst_n = 1'b0;
    a = 8'h00; b = 8'h01; c = 8'h00; d = 8'h01;
    sel = 2'b00;
    #2;
    check("reset_out_q", out_q, 8'h00);
    check("reset_sel_chg", {7'd0, sel_chg}, 8'h00);

    // Combinational sweep while held in reset: out tracks without any register.
    check("comb_sel00", out, 8'h00);
    sel = 2'b01; #1 check("comb_sel01", out, 8'h01);
    #9 sel = 2'b10; #1 check("comb_sel10", out, 8'h00);
    #9 sel = 2'b11; #1 check("comb_sel11", out, 8'h01);
    check("reset_hold_out_q", out_q, 8'h00);

    // Data change at fixed select, then walk the select back down.
    a = 8'h01; b = 8'h00; c = 8'h01; d = 8'h00;
    #1 check("data_chg_sel11", out, 8'h00);
    sel = 2'b10; #1 check("data_chg_sel10", out, 8'h01);
    sel = 2'b01; #1 check("data_chg_sel01", out, 8'h00);
    sel = 2'b00; #1 check("data_chg_sel00", out, 8'h01);

    // Release between edges, then clocked sweep with a=0,b=1,c=0,d=1.
    @(negedge clk);
    rst_n = 1'b1;
    a = 8'h00; b = 8'h01; c = 8'h00; d = 8'h01;
    for (int s = 0; s < 4; s++) begin
      sel = s[1:0];
      #1 check("sweep_out", out, pick(a, b, c, d, sel));
      tick();
      check_regs("sweep");
      check("sweep_out_q_const", out_q, {7'd0, s[0]});
    end
    tick();
    check("sweep_chg_drop", {7'd0, sel_chg}, 8'h00);

    // Async reset between edges: registers clear at once, out keeps tracking.
    sel = 2'b01; b = 8'h01;
    tick();
    tick();
    check("pre_rst_out_q", out_q, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_q", out_q, 8'h00);
    check("async_rst_sel_chg", {7'd0, sel_chg}, 8'h00);
    check("async_rst_out", out, 8'h01);
    #1 rst_n = 1'b1;
    tick();
    check("post_rst_out_q", out_q, 8'h01);
    check("post_rst_sel_chg", {7'd0, sel_chg}, 8'h01);

    // Full-width distinct values.
    a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44;
    for (int s = 0; s < 4; s++) begin
      sel = s[1:0];
      #1 check("width_out", out, pick(8'h11, 8'h22, 8'h33, 8'h44, s[1:0]));
      tick();
      check_regs("width");
    end

    // Stable select: one pulse on entering 10, then quiet.
    sel = 2'b10;
    tick();
    check("stable_first_pulse", {7'd0, sel_chg}, 8'h01);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stable_quiet", {7'd0, sel_chg}, 8'h00);
      check("stable_out_q", out_q, 8'h33);
    end

    // Randomised traffic with occasional mid-cycle async resets.
    for (int i = 0; i < 200; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
      sel = 2'($urandom_range(0, 3));
      #1 check("rand_out", out, pick(a, b, c, d, sel));
      if ($urandom_range(0, 15) == 0) begin
        rst_n = 1'b0;
        #1;
        check("rand_rst_out_q", out_q, 8'h00);
        check("rand_rst_sel_chg", {7'd0, sel_chg}, 8'h00);
        rst_n = 1'b1;
      end
      tick();
      check_regs("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
